// File: rtl/mine_pkg.sv
// Shared definitions for the mine placer: FSM encoding, board geometry and
// the seed used when the requester supplies a zero seed.
// Ports: none (package only).
package mine_pkg;

  // Placer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_DRAW  = 3'd3,
    ST_CHECK = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  // Board is 16x16 cells, addressed row*16+col.
  localparam int CELLS = 256;

  // At least two cells must remain free: the safe cell and one spare, so a
  // request above this count can never be satisfied.
  localparam int MAX_MINES = 254;

  // An all-zero seed locks an LFSR, so it is replaced by this value.
  localparam logic [7:0] DEF_SEED = 8'hE2;

  // Seed actually handed to the random generator.
  function automatic logic [7:0] pick_seed(input logic [7:0] s,
                                           input logic [7:0] def_seed);
    return (s == 8'h00) ? def_seed : s;
  endfunction

endpackage

// File: rtl/mine_placer.sv
// Purpose : seeds an external RanGen, clears the 256-cell board, then places
//           mine_count mines at distinct random cells, never on safe_cell.
// Latency : 2 cycles for a rejected request; otherwise 1 + 256 clear cycles
//           + 2 cycles per draw + 1 FIN cycle.
// Backpr. : none; start is accepted only in IDLE and ignored while busy.
// Ports   : clk/reset (sync, active-high); start/seed/mine_count/safe_cell
//           request; rnd_load/rnd_seed/rnd_en/rnd_y to the RanGen; board_we/
//           board_addr/board_data to the board RAM; busy/done/err status.
module mine_placer #(
  parameter int         GUARD    = 255,
  parameter logic [7:0] DEF_SEED = mine_pkg::DEF_SEED
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] seed,
  input  logic [7:0] mine_count,
  input  logic [7:0] safe_cell,
  output logic       rnd_load,
  output logic [7:0] rnd_seed,
  output logic       rnd_en,
  input  logic [7:0] rnd_y,
  output logic       board_we,
  output logic [7:0] board_addr,
  output logic       board_data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  import mine_pkg::*;

  localparam logic [7:0] GUARD_L     = 8'(GUARD);
  localparam logic [7:0] MAX_MINES_L = 8'(MAX_MINES);

  state_t state, state_n;

  // Request fields latched on an accepted start.
  logic [7:0] seed_q;
  logic [7:0] count_q;
  logic [7:0] safe_q;

  // Run counters.
  logic [7:0] clr_idx;   // CLEAR write address, 0..255
  logic [7:0] placed;    // mines placed so far
  logic [7:0] rej;       // consecutive rejected draws
  logic       err_q;     // outcome reported with done

  // Occupancy bitmap; initialised only by CLEAR, never by reset.
  logic [CELLS-1:0] bitmap;

  logic       hit;
  logic [7:0] rej_inc;
  logic [7:0] placed_inc;

  // A draw is rejected when it lands on the safe cell or an occupied cell.
  assign hit        = (rnd_y == safe_q) || bitmap[rnd_y];
  // Reject counter saturates at GUARD.
  assign rej_inc    = (rej == GUARD_L) ? rej : rej + 8'd1;
  assign placed_inc = placed + 8'd1;

  // State register and run bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      seed_q  <= 8'h00;
      count_q <= 8'h00;
      safe_q  <= 8'h00;
      clr_idx <= 8'h00;
      placed  <= 8'h00;
      rej     <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            seed_q  <= seed;
            count_q <= mine_count;
            safe_q  <= safe_cell;
            clr_idx <= 8'h00;
            placed  <= 8'h00;
            rej     <= 8'h00;
            err_q   <= 1'b0;
          end
        end
        ST_SEED: begin
          // Unsatisfiable request: flagged here, FIN follows immediately.
          err_q <= (count_q > MAX_MINES_L);
        end
        ST_CLEAR: begin
          clr_idx <= clr_idx + 8'd1;
        end
        ST_CHECK: begin
          if (hit) begin
            rej <= rej_inc;
            if (rej_inc == GUARD_L) begin
              err_q <= 1'b1;
            end
          end else begin
            placed <= placed_inc;
            rej    <= 8'h00;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Bitmap has no reset: it is wiped one cell per CLEAR cycle and a cell is
  // marked when a draw is accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_CLEAR) begin
        bitmap[clr_idx] <= 1'b0;
      end else if (state == ST_CHECK && !hit) begin
        bitmap[rnd_y] <= 1'b1;
      end
    end
  end

  // Next state and Moore/Mealy outputs.
  always_comb begin
    state_n    = state;
    rnd_load   = 1'b0;
    rnd_seed   = 8'h00;
    rnd_en     = 1'b0;
    board_we   = 1'b0;
    board_addr = 8'h00;
    board_data = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_SEED;
        end
      end
      ST_SEED: begin
        busy     = 1'b1;
        rnd_load = 1'b1;
        rnd_seed = pick_seed(seed_q, DEF_SEED);
        state_n  = (count_q > MAX_MINES_L) ? ST_FIN : ST_CLEAR;
      end
      ST_CLEAR: begin
        busy       = 1'b1;
        board_we   = 1'b1;
        board_addr = clr_idx;
        if (clr_idx == 8'hFF) begin
          state_n = (count_q == 8'h00) ? ST_FIN : ST_DRAW;
        end
      end
      ST_DRAW: begin
        busy    = 1'b1;
        rnd_en  = 1'b1;
        state_n = ST_CHECK;
      end
      ST_CHECK: begin
        busy = 1'b1;
        if (hit) begin
          state_n = (rej_inc == GUARD_L) ? ST_FIN : ST_DRAW;
        end else begin
          board_we   = 1'b1;
          board_addr = rnd_y;
          board_data = 1'b1;
          state_n    = (placed_inc == count_q) ? ST_FIN : ST_DRAW;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        err     = err_q;
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mine_placer.sv
// Bench for mine_placer: a behavioural 8-bit Galois LFSR stands in for RanGen,
// a stimulus process issues requests and queues their expected outcomes, and
// a monitor tallies board traffic and checks each done against the queue.
module tb_mine_placer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] seed;
  logic [7:0] mine_count;
  logic [7:0] safe_cell;
  logic       rnd_load;
  logic [7:0] rnd_seed;
  logic       rnd_en;
  logic [7:0] rnd_y;
  logic       board_we;
  logic [7:0] board_addr;
  logic       board_data;
  logic       busy;
  logic       done;
  logic       err;

  always #5 clk = ~clk;

  mine_placer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .seed       (seed),
    .mine_count (mine_count),
    .safe_cell  (safe_cell),
    .rnd_load   (rnd_load),
    .rnd_seed   (rnd_seed),
    .rnd_en     (rnd_en),
    .rnd_y      (rnd_y),
    .board_we   (board_we),
    .board_addr (board_addr),
    .board_data (board_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // RanGen stand-in: load on rnd_load, one Galois step (taps 0xB8) on rnd_en.
  logic [7:0] lfsr = 8'h00;
  logic       force_const = 1'b0;
  always @(posedge clk) begin
    if (rnd_load) lfsr <= rnd_seed;
    else if (rnd_en) lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
  end
  assign rnd_y = force_const ? 8'h33 : lfsr;

  typedef struct {
    int err;
    int clr;
    int ones;
    int first;      // first mine address, -1 = no mine expected
    int load_seed;
    int en_cnt;     // -1 = don't care
    int lat;        // start-to-done cycles, -1 = don't care
  } exp_t;

  exp_t expq[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  logic [7:0] cur_safe = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Monitor state for the run in progress.
  int clr_w, one_w, dup, safe_hit, order_bad, first, en_cnt, load_seed_seen;
  bit mark [256];
  bit prev_reset = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (prev_reset) begin
      chk("reset_outputs",
          int'({rnd_load, rnd_en, board_we, board_data, busy, done, err, rnd_seed, board_addr}), 0);
    end
    prev_reset = reset;
    if (!reset) begin
      if (rnd_load) begin
        clr_w = 0; one_w = 0; dup = 0; safe_hit = 0; order_bad = 0;
        first = -1; en_cnt = 0; load_seed_seen = int'(rnd_seed);
        foreach (mark[i]) mark[i] = 1'b0;
      end
      if (rnd_en) en_cnt++;
      if (board_we && !board_data) begin
        if (int'(board_addr) != clr_w) order_bad++;
        clr_w++;
      end
      if (board_we && board_data) begin
        if (mark[board_addr]) dup++;
        mark[board_addr] = 1'b1;
        if (board_addr == cur_safe) safe_hit++;
        if (first < 0) first = int'(board_addr);
        one_w++;
      end
      if (done) begin
        done_cnt++;
        if (expq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("err", int'(err), e.err);
          chk("clear_writes", clr_w, e.clr);
          chk("mine_writes", one_w, e.ones);
          chk("dup_mines", dup, 0);
          chk("safe_mined", safe_hit, 0);
          chk("clear_order", order_bad, 0);
          chk("first_mine", first, e.first);
          chk("load_seed", load_seed_seen, e.load_seed);
          if (e.en_cnt >= 0) chk("rnd_en_count", en_cnt, e.en_cnt);
          if (e.lat >= 0) chk("latency", cyc - start_cyc, e.lat);
        end
      end
    end
  end

  task automatic run(input logic [7:0] s, input logic [7:0] mc, input logic [7:0] sf,
                     input bit fc, input exp_t e, input bit poke);
    int n;
    @(posedge clk); #1;
    seed = s; mine_count = mc; safe_cell = sf; force_const = fc; cur_safe = sf;
    start = 1'b1;
    start_cyc = cyc;
    expq.push_back(e);
    n = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble inputs: the run must use the latched values.
    seed = 8'hFF; mine_count = 8'hFF; safe_cell = 8'h00;
    if (poke) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int i = 0; i < 3000 && done_cnt == n; i++) @(posedge clk);
    if (done_cnt == n) chk("done_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1 force_const = 1'b0;
  endtask

  initial begin
    int d;
    int found;
    reset = 1'b1; start = 1'b0; seed = 8'h00; mine_count = 8'h00; safe_cell = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    // Typical board; a stray start mid-run must be ignored.
    run(8'h5A, 8'd40, 8'h11, 1'b0, '{0, 256, 40, 8'h2D, 8'h5A, -1, -1}, 1'b1);
    // Zero seed replaced by 0xE2; first step gives 0x71.
    run(8'h00, 8'd1, 8'h00, 1'b0, '{0, 256, 1, 8'h71, 8'hE2, 1, 260}, 1'b0);
    // Over-limit count: rejected without touching the board.
    run(8'h5A, 8'hFF, 8'h00, 1'b0, '{1, 0, 0, -1, 8'h5A, 0, 2}, 1'b0);
    // Zero mines: clear only.
    run(8'h5A, 8'd0, 8'h00, 1'b0, '{0, 256, 0, -1, 8'h5A, 0, 258}, 1'b0);
    // Stuck generator: one mine, then 255 rejects abort the run.
    run(8'h5A, 8'd2, 8'h00, 1'b1, '{1, 256, 1, 8'h33, 8'h5A, 256, 770}, 1'b0);
    // Maximum legal count.
    run(8'h5A, 8'd254, 8'h00, 1'b0, '{0, 256, 254, 8'h2D, 8'h5A, 254, 766}, 1'b0);

    // Reset during the 100th CLEAR cycle abandons the run silently.
    @(posedge clk); #1;
    seed = 8'h5A; mine_count = 8'd10; safe_cell = 8'h11; cur_safe = 8'h11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 400; i++) begin
      if (board_we && !board_data && board_addr == 8'd99) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("reached_clear_99", found, 1);
    d = done_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    chk("no_done_after_reset", done_cnt - d, 0);
    run(8'h5A, 8'd3, 8'h11, 1'b0, '{0, 256, 3, 8'h2D, 8'h5A, 3, 264}, 1'b0);

    repeat (4) @(posedge clk);
    chk("pending_expectations", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mine_placer.md
MINE_PLACER -- requirements
Module: mine_placer

Interface
REQ-001 Parameter GUARD, default 255, max consecutive rejected draws before abort.
REQ-002 Parameter DEF_SEED, default 8'hE2, substitute for a zero seed.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 start  in  1  one-cycle request to populate the board; ignored while busy.
REQ-006 seed  in  8  LFSR seed, sampled on accepted start.
REQ-007 mine_count  in  8  mines to place, sampled on accepted start.
REQ-008 safe_cell  in  8  cell that must never be mined, sampled on accepted start.
REQ-009 rnd_load  out  1  one-cycle pulse; RanGen loads rnd_seed.
REQ-010 rnd_seed  out  8  seed value presented to RanGen.
REQ-011 rnd_en  out  1  one-cycle pulse; RanGen advances one step.
REQ-012 rnd_y  in  8  RanGen output, valid the cycle after rnd_load or rnd_en.
REQ-013 board_we  out  1  board RAM write strobe.
REQ-014 board_addr  out  8  board cell index, row*16+col.
REQ-015 board_data  out  1  1 = mine, 0 = empty.
REQ-016 busy  out  1  high from the cycle after an accepted start until done.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 err  out  1  valid with done; 1 = request rejected or aborted.

Function
REQ-019 FSM states: IDLE, SEED, CLEAR, DRAW, CHECK, FIN.
REQ-020 IDLE + start: latch inputs, go to SEED; start in any other state ignored.
REQ-021 SEED, 1 cycle: rnd_load=1; rnd_seed = latched seed, or DEF_SEED if seed==0; go to CLEAR.
REQ-022 CLEAR, exactly 256 cycles: board_we=1, board_data=0, board_addr 0..255 ascending; occupancy bitmap cleared; go to DRAW.
REQ-023 mine_count > 254: skip CLEAR, go to FIN with err=1; board untouched.
REQ-024 mine_count==0: after CLEAR go to FIN with err=0.
REQ-025 DRAW, 1 cycle: rnd_en=1; go to CHECK.
REQ-026 CHECK, 1 cycle: reject if rnd_y==safe_cell or bitmap[rnd_y] set; otherwise accept.
REQ-027 Accept: board_we=1, board_addr=rnd_y, board_data=1, set bitmap[rnd_y], placed+1, reject counter cleared; FIN if placed==mine_count, else DRAW.
REQ-028 Reject: no write; reject counter+1; when it reaches GUARD go to FIN with err=1, else DRAW.
REQ-029 Steady-state rate: one mine per 2 cycles when no rejects.
REQ-030 FIN, 1 cycle: done=1, err as decided, busy=0; go to IDLE.
REQ-031 The same cell is never written with 1 twice in one run; at most mine_count cells are written with 1.
REQ-032 Counters are 8-bit; the reject counter saturates at GUARD; placed never exceeds mine_count.

Reset
REQ-033 reset takes priority over all inputs: state=IDLE, counters=0, next cycle all outputs 0 (rnd_seed=0, board_addr=0).
REQ-034 reset in mid-run abandons the run without a done pulse; a partially written board is cleared by the next run's CLEAR.
REQ-035 Bitmap contents are not reset; CLEAR alone initialises them.

Structure
REQ-036 Shared package mine_pkg holds the state encoding, CELLS=256, MAX_MINES=254 and DEF_SEED=8'hE2.
REQ-037 No sub-module: RanGen is instantiated alongside, not inside; the bitmap is a 256-bit register in this module.

Verification
REQ-038 seed=8'h5A, mine_count=40, safe_cell=8'h11 -> 256 clear writes, then exactly 40 distinct 1-writes, none to 8'h11; done with err=0.
REQ-039 seed=8'h00, mine_count=1 -> rnd_seed=8'hE2 on the rnd_load cycle; one mine written; err=0.
REQ-040 mine_count=8'hFF -> done 2 cycles after start, err=1, no board_we.
REQ-041 mine_count=0 -> 256 clear writes, then done with err=0, no 1-writes.
REQ-042 rnd_y forced constant 8'h33 and mine_count=2 -> first mine at 8'h33, then 255 rejects, then done with err=1.
REQ-043 reset asserted in the 100th CLEAR cycle -> all outputs 0 next cycle, no done; the next start completes normally.
